ir_intf: RTL and testbench
==========================

// Module: ir_intf
// PURPOSE
//  Periodically powers the 8 IR emitters and lets the line settle.
//  Then sequences 8 A2D conversions (channels 0..7) over a strt_cnv/cnv_cmplt handshake.
//  Publishes the 8 readings atomically and pulses IR_vld.
//  Sits directly upstream of the error-compute stage, which starts an 8-cycle sel sweep on IR_vld.
// PARAMETERS
//  PERIOD  1048576  clk cycles between scan starts (timer width = $clog2(PERIOD))
//  SETTLE  4096     clk cycles IR_en is high before the first conversion (>=1)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  rst_n      in   1   asynchronous active-low reset
//  cnv_cmplt  in   1   A2D conversion done; res valid in the same cycle
//  res        in   12  A2D result, unsigned
//  strt_cnv   out  1   one-cycle pulse: start conversion on chnnl
//  chnnl      out  3   A2D channel select (= current index)
//  IR_en      out  1   IR emitter enable
//  IR_vld     out  1   one-cycle pulse: IR_0..IR_7 updated
//  IR_0..IR_7 out  12  published readings; IR_n = channel n
// BEHAVIOUR
//  Reset: state IDLE, timer=0, settle cnt=0, idx=0.
//   strt_cnv=IR_en=IR_vld=0, chnnl=0, IR_0..7=0, working regs=0.
//  Period timer:
//   free-runs 0..PERIOD-1 and wraps to 0, independent of state.
//   tick = (timer==PERIOD-1).
//  FSM (Moore outputs):
//   IDLE:  IR_en=0. On tick -> SETTLE (settle cnt cleared, idx cleared).
//   SETTLE: IR_en=1. Settle cnt increments each cycle.
//     At cnt==SETTLE-1 -> STRT, i.e. exactly SETTLE cycles in SETTLE.
//   STRT:  IR_en=1, strt_cnv=1 for this single cycle. -> WAIT next cycle.
//   WAIT:  IR_en=1. On cnv_cmplt, work[idx]<=res at that edge; then:
//     idx<7:  idx<=idx+1 -> STRT.
//     idx==7: -> DONE.
//     No cnv_cmplt: stay in WAIT (no timeout).
//   DONE:  IR_en=0, IR_vld=1 for this single cycle.
//     IR_0..7 <= work[0..7], all copied on the edge entering DONE.
//     IR_vld therefore coincides with new, stable values. -> IDLE.
//  chnnl = idx at all times.
//  Published IR_n change only on entry to DONE and hold otherwise.
//  Latency: tick edge to first strt_cnv = SETTLE+1 cycles.
//   Last cnv_cmplt to IR_vld = 1 cycle.
//  Boundary cases:
//   tick outside IDLE: dropped; no queueing, no restart. The next scan waits for the next tick.
//   cnv_cmplt in IDLE/SETTLE/STRT/DONE: ignored, no capture.
//   idx never exceeds 7; it wraps only via clear on IDLE->SETTLE.
//   rst_n low mid-scan: immediate return to reset values; partial readings discarded.
//   IR_vld and strt_cnv are never high in the same cycle.
//  Widths: res captured unmodified (12b). No arithmetic on data.
// TESTING (bench uses PERIOD=64, SETTLE=4, A2D model answers 3 cycles after strt_cnv)
//  1. Reset release, no stimulus:
//     IR_en rises at cycle 64 (timer wrap).
//     First strt_cnv 5 cycles after tick with chnnl=0.
//  2. Model returns res=0x100+ch:
//     8 strt_cnv pulses on chnnl 0..7 in order.
//     IR_vld one cycle after 8th cnv_cmplt; IR_0=0x100 .. IR_7=0x107; IR_en=0 in the same cycle.
//  3. Second scan returns 0xFFF-ch:
//     IR_0..7 hold old values through the whole scan.
//     All 8 switch together on the IR_vld cycle.
//  4. Delay cnv_cmplt on ch3 by 200 cycles (>PERIOD):
//     FSM stays in WAIT; missed ticks dropped.
//     Scan completes with correct data; the next scan starts on the next tick after IDLE.
//  5. Spurious cnv_cmplt during SETTLE and STRT with res=0xABC:
//     no capture; readings unaffected.
//  6. Assert rst_n low while waiting on ch5:
//     all outputs 0 asynchronously.
//     After release, a fresh scan starts at ch0 after the next tick.

Source files
------------

// File: rtl/ir_intf_if.sv
// Bundle between the IR scan sequencer, the A2D converter and the downstream error stage.
// The master side is the sequencer; the slave side is the converter plus reading consumer.
interface ir_if;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_en;
    logic        IR_vld;
    logic [11:0] IR_0;
    logic [11:0] IR_1;
    logic [11:0] IR_2;
    logic [11:0] IR_3;
    logic [11:0] IR_4;
    logic [11:0] IR_5;
    logic [11:0] IR_6;
    logic [11:0] IR_7;

    modport master (
        input  cnv_cmplt, res,
        output strt_cnv, chnnl, IR_en, IR_vld,
        output IR_0, IR_1, IR_2, IR_3, IR_4, IR_5, IR_6, IR_7
    );

    modport slave (
        output cnv_cmplt, res,
        input  strt_cnv, chnnl, IR_en, IR_vld,
        input  IR_0, IR_1, IR_2, IR_3, IR_4, IR_5, IR_6, IR_7
    );
endinterface

// File: rtl/ir_intf.sv
// IR scan sequencer: powers the emitters each period, settles, converts channels 0..7,
// then publishes all eight readings together with a one-cycle IR_vld pulse.
//
// state    | meaning
// ST_IDLE  | emitters off, waiting for the period tick
// ST_SETTL | emitters on, letting the line settle
// ST_STRT  | strt_cnv pulse for channel idx
// ST_WAIT  | waiting for cnv_cmplt on channel idx
// ST_DONE  | readings published, IR_vld pulse
module ir_intf #(
    parameter int PERIOD = 1048576,
    parameter int SETTLE = 4096
) (
    input  logic clk,
    input  logic rst_n,
    ir_if.master bus
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTL,
        ST_STRT,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [SW-1:0] r_settle_cnt;
    logic [2:0]    r_idx;
    logic [11:0]   r_work [8];
    logic [11:0]   r_ir   [8];
    logic          r_strt;
    logic          r_en;
    logic          r_vld;
    logic          w_tick;

    assign w_tick = (r_timer == TW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_idx        <= '0;
            r_strt       <= 1'b0;
            r_en         <= 1'b0;
            r_vld        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_work[i] <= '0;
                r_ir[i]   <= '0;
            end
        end else begin
            r_strt <= 1'b0;
            r_vld  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state      <= ST_SETTL;
                        r_settle_cnt <= '0;
                        r_idx        <= '0;
                        r_en         <= 1'b1;
                    end
                end
                ST_SETTL: begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                    if (r_settle_cnt == SW'(SETTLE - 1)) begin
                        r_state <= ST_STRT;
                        r_strt  <= 1'b1;
                    end
                end
                ST_STRT: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.cnv_cmplt) begin
                        r_work[r_idx] <= bus.res;
                        if (r_idx == 3'd7) begin
                            // Channel 7 lands this edge, so publish it straight from res.
                            for (int i = 0; i < 7; i++) begin
                                r_ir[i] <= r_work[i];
                            end
                            r_ir[7] <= bus.res;
                            r_state <= ST_DONE;
                            r_en    <= 1'b0;
                            r_vld   <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_STRT;
                            r_strt  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.strt_cnv = r_strt;
    assign bus.chnnl    = r_idx;
    assign bus.IR_en    = r_en;
    assign bus.IR_vld   = r_vld;
    assign bus.IR_0     = r_ir[0];
    assign bus.IR_1     = r_ir[1];
    assign bus.IR_2     = r_ir[2];
    assign bus.IR_3     = r_ir[3];
    assign bus.IR_4     = r_ir[4];
    assign bus.IR_5     = r_ir[5];
    assign bus.IR_6     = r_ir[6];
    assign bus.IR_7     = r_ir[7];
endmodule

// File: tb/tb_ir_intf.sv
// Bench for ir_intf: an A2D responder model plus per-scenario tasks comparing
// observed scan timing and published readings against a cycle-arithmetic model.
module tb_ir_intf;
    localparam int PERIOD = 64;
    localparam int SETTLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ir_if bus ();

    ir_intf #(.PERIOD(PERIOD), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // cycle index k = number of posedges since reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // A2D responder: answers dly[ch] cycles after strt_cnv; optional spurious completes
    logic [11:0] tbl [8];
    int          dly [8];
    bit          spur_en = 1'b0;
    int          pend;
    logic [11:0] pend_res;

    initial begin
        bus.cnv_cmplt = 1'b0;
        bus.res       = 12'h000;
        pend          = 0;
        pend_res      = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            bus.cnv_cmplt = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.cnv_cmplt = 1'b1;
                    bus.res       = pend_res;
                end
            end else if (spur_en && bus.IR_en) begin
                bus.cnv_cmplt = 1'b1;
                bus.res       = 12'hABC;
            end
            if (rst_n && bus.strt_cnv) begin
                pend     = dly[bus.chnnl];
                pend_res = tbl[bus.chnnl];
            end
        end
    end

    function automatic logic [11:0] ir_get(input int n);
        case (n)
            0: return bus.IR_0;
            1: return bus.IR_1;
            2: return bus.IR_2;
            3: return bus.IR_3;
            4: return bus.IR_4;
            5: return bus.IR_5;
            6: return bus.IR_6;
            default: return bus.IR_7;
        endcase
    endfunction

    // Reference model: scan timing from the period grid and per-channel answer delays
    logic [11:0] exp_ir [8];
    int exp_en;
    int exp_strt [8];
    int exp_vld;
    int last_vld;

    task automatic model_scan(input int idle_from);
        int tick;
        tick = idle_from + (PERIOD - 1 - (idle_from % PERIOD));
        exp_en = tick + 1;
        exp_strt[0] = tick + 1 + SETTLE;
        for (int i = 1; i < 8; i++) exp_strt[i] = exp_strt[i-1] + dly[i-1] + 1;
        exp_vld = exp_strt[7] + dly[7] + 1;
    endtask

    // Observation of one scan, sampled on negedges
    int q_ch [$];
    int q_strt [$];
    int en_rise;
    int vld_cyc;
    int early_chg;
    int overlap;
    int vld_en;
    logic [11:0] ir_at_vld [8];
    logic [11:0] ir_start  [8];

    task automatic watch(input int budget);
        logic [11:0] prev [8];
        logic en_prev;
        q_ch.delete();
        q_strt.delete();
        en_rise = -1; vld_cyc = -1; early_chg = 0; overlap = 0; vld_en = 0;
        for (int n = 0; n < 8; n++) begin
            prev[n] = ir_get(n);
            ir_start[n] = prev[n];
            ir_at_vld[n] = 12'h000;
        end
        en_prev = bus.IR_en;
        for (int i = 0; i < budget && vld_cyc < 0; i++) begin
            @(negedge clk);
            if (bus.IR_en && !en_prev && en_rise < 0) en_rise = cyc;
            en_prev = bus.IR_en;
            if (bus.strt_cnv) begin
                q_ch.push_back(int'(bus.chnnl));
                q_strt.push_back(cyc);
            end
            if (bus.strt_cnv && bus.IR_vld) overlap++;
            if (bus.IR_vld) begin
                vld_cyc = cyc;
                if (bus.IR_en) vld_en++;
                for (int n = 0; n < 8; n++) ir_at_vld[n] = ir_get(n);
            end else begin
                for (int n = 0; n < 8; n++) if (ir_get(n) !== prev[n]) early_chg++;
            end
        end
    endtask

    task automatic rand_tbl(input int dmax);
        for (int i = 0; i < 8; i++) begin
            tbl[i] = 12'($urandom_range(4095, 0));
            dly[i] = (dmax <= 1) ? 3 : int'($urandom_range(dmax, 1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin tbl[i] = 12'h000; dly[i] = 3; end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.strt_cnv, bus.IR_en, bus.IR_vld, bus.chnnl} !== 6'd0) begin
            fails++;
            $display("FAIL reset_ctrl got %b expected 000000", {bus.strt_cnv, bus.IR_en, bus.IR_vld, bus.chnnl});
        end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_get(n) !== 12'h000) begin
                fails++;
                $display("FAIL reset_IR_%0d got %h expected 000", n, ir_get(n));
            end
            exp_ir[n] = 12'h000;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_scan();
        for (int i = 0; i < 8; i++) begin tbl[i] = 12'h100 + 12'(i); dly[i] = 3; end
        model_scan(0);
        watch(400);
        tests_run++;
        if (en_rise !== 64) begin fails++; $display("FAIL first_en_rise got %0d expected 64", en_rise); end
        tests_run++;
        if (q_ch.size() !== 8) begin fails++; $display("FAIL first_strt_count got %0d expected 8", q_ch.size()); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ((i < q_ch.size() ? q_ch[i] : -1) !== i || (i < q_strt.size() ? q_strt[i] : -1) !== exp_strt[i]) begin
                fails++;
                $display("FAIL first_strt_%0d got ch %0d cyc %0d expected ch %0d cyc %0d", i,
                         (i < q_ch.size() ? q_ch[i] : -1), (i < q_strt.size() ? q_strt[i] : -1), i, exp_strt[i]);
            end
        end
        tests_run++;
        if (vld_cyc !== exp_vld || vld_en !== 0 || overlap !== 0 || early_chg !== 0) begin
            fails++;
            $display("FAIL first_vld got cyc %0d en %0d ovl %0d early %0d expected cyc %0d en 0 ovl 0 early 0",
                     vld_cyc, vld_en, overlap, early_chg, exp_vld);
        end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_at_vld[n] !== tbl[n]) begin fails++; $display("FAIL first_IR_%0d got %h expected %h", n, ir_at_vld[n], tbl[n]); end
        end
        exp_ir = tbl;
        last_vld = vld_cyc;
    endtask

    task automatic test_second_scan();
        for (int i = 0; i < 8; i++) begin tbl[i] = 12'hFFF - 12'(i); dly[i] = 3; end
        model_scan(last_vld + 1);
        watch(400);
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_start[n] !== exp_ir[n] || ir_at_vld[n] !== tbl[n]) begin
                fails++;
                $display("FAIL second_IR_%0d got old %h new %h expected old %h new %h", n, ir_start[n], ir_at_vld[n], exp_ir[n], tbl[n]);
            end
        end
        tests_run++;
        if (early_chg !== 0 || en_rise !== exp_en || vld_cyc !== exp_vld) begin
            fails++;
            $display("FAIL second_hold got early %0d en %0d vld %0d expected early 0 en %0d vld %0d",
                     early_chg, en_rise, vld_cyc, exp_en, exp_vld);
        end
        exp_ir = tbl;
        last_vld = vld_cyc;
    endtask

    task automatic test_long_wait();
        rand_tbl(1);
        dly[3] = 200;
        model_scan(last_vld + 1);
        watch(800);
        tests_run++;
        if (q_ch.size() !== 8 || (q_strt.size() > 4 ? q_strt[4] : -1) !== exp_strt[4]) begin
            fails++;
            $display("FAIL long_strt got count %0d ch4 cyc %0d expected count 8 ch4 cyc %0d",
                     q_ch.size(), (q_strt.size() > 4 ? q_strt[4] : -1), exp_strt[4]);
        end
        tests_run++;
        if (vld_cyc !== exp_vld || early_chg !== 0) begin
            fails++;
            $display("FAIL long_vld got cyc %0d early %0d expected cyc %0d early 0", vld_cyc, early_chg, exp_vld);
        end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_at_vld[n] !== tbl[n]) begin fails++; $display("FAIL long_IR_%0d got %h expected %h", n, ir_at_vld[n], tbl[n]); end
        end
        exp_ir = tbl;
        last_vld = vld_cyc;
        // the following scan must wait for the first tick after returning to idle
        rand_tbl(1);
        model_scan(last_vld + 1);
        watch(400);
        tests_run++;
        if (en_rise !== exp_en || vld_cyc !== exp_vld) begin
            fails++;
            $display("FAIL long_next got en %0d vld %0d expected en %0d vld %0d", en_rise, vld_cyc, exp_en, exp_vld);
        end
        exp_ir = tbl;
        last_vld = vld_cyc;
    endtask

    task automatic test_spurious();
        rand_tbl(6);
        spur_en = 1'b1;
        model_scan(last_vld + 1);
        watch(600);
        spur_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ((i < q_ch.size() ? q_ch[i] : -1) !== i || (i < q_strt.size() ? q_strt[i] : -1) !== exp_strt[i]) begin
                fails++;
                $display("FAIL spur_strt_%0d got ch %0d cyc %0d expected ch %0d cyc %0d", i,
                         (i < q_ch.size() ? q_ch[i] : -1), (i < q_strt.size() ? q_strt[i] : -1), i, exp_strt[i]);
            end
        end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_at_vld[n] !== tbl[n]) begin fails++; $display("FAIL spur_IR_%0d got %h expected %h", n, ir_at_vld[n], tbl[n]); end
        end
        exp_ir = tbl;
        last_vld = vld_cyc;
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            rand_tbl(8);
            model_scan(last_vld + 1);
            watch(600);
            tests_run++;
            if (en_rise !== exp_en || vld_cyc !== exp_vld || overlap !== 0 || vld_en !== 0 || early_chg !== 0 || q_ch.size() !== 8) begin
                fails++;
                $display("FAIL b2b_%0d_timing got en %0d vld %0d ovl %0d ven %0d early %0d n %0d expected en %0d vld %0d 0 0 0 8",
                         s, en_rise, vld_cyc, overlap, vld_en, early_chg, q_ch.size(), exp_en, exp_vld);
            end
            for (int n = 0; n < 8; n++) begin
                tests_run++;
                if (ir_start[n] !== exp_ir[n] || ir_at_vld[n] !== tbl[n]) begin
                    fails++;
                    $display("FAIL b2b_%0d_IR_%0d got old %h new %h expected old %h new %h", s, n, ir_start[n], ir_at_vld[n], exp_ir[n], tbl[n]);
                end
            end
            exp_ir = tbl;
            last_vld = vld_cyc;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        rand_tbl(1);
        dly[5] = 5000;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (bus.strt_cnv && bus.chnnl == 3'd5) found = 1'b1;
        end
        tests_run++;
        if (found !== 1'b1) begin fails++; $display("FAIL midrst_reach_ch5 got %0d expected 1", found); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.strt_cnv, bus.IR_en, bus.IR_vld, bus.chnnl} !== 6'd0) begin
            fails++;
            $display("FAIL midrst_ctrl got %b expected 000000", {bus.strt_cnv, bus.IR_en, bus.IR_vld, bus.chnnl});
        end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_get(n) !== 12'h000) begin fails++; $display("FAIL midrst_IR_%0d got %h expected 000", n, ir_get(n)); end
            exp_ir[n] = 12'h000;
        end
        dly[5] = 3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_scan(0);
        watch(400);
        tests_run++;
        if (en_rise !== 64 || (q_ch.size() > 0 ? q_ch[0] : -1) !== 0 || (q_strt.size() > 0 ? q_strt[0] : -1) !== 68) begin
            fails++;
            $display("FAIL midrst_restart got en %0d ch %0d cyc %0d expected en 64 ch 0 cyc 68",
                     en_rise, (q_ch.size() > 0 ? q_ch[0] : -1), (q_strt.size() > 0 ? q_strt[0] : -1));
        end
        tests_run++;
        if (vld_cyc !== exp_vld) begin fails++; $display("FAIL midrst_vld got %0d expected %0d", vld_cyc, exp_vld); end
        for (int n = 0; n < 8; n++) begin
            tests_run++;
            if (ir_start[n] !== 12'h000 || ir_at_vld[n] !== tbl[n]) begin
                fails++;
                $display("FAIL midrst_IR_%0d got old %h new %h expected old 000 new %h", n, ir_start[n], ir_at_vld[n], tbl[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_second_scan();
        test_long_wait();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
